// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared memory-access size and store-unit state encodings.
package cpu_types_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11} mem_size_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} sws_state_t;
  function automatic logic misaligned(input mem_size_t s, input logic [1:0] off);
    return s == RSVD || (s == HALF && off[0]) || (s == WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/subword_merge.sv
// subword_merge: inserts a byte/halfword operand into its lane of an existing word.
module subword_merge
  import cpu_types_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] operand,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  output logic [31:0] merged
);
  logic [1:0] byte_lane;
  logic       half_lane;
  // Physical lane index: big-endian puts offset 0 in the top byte.
  assign byte_lane = BIG_ENDIAN ? ~offset : offset;
  assign half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = size == WORD ? operand[8*i +: 8] :
                              (size == BYTE && byte_lane == 2'(i)) ? operand[7:0] :
                              (size == HALF && half_lane == 1'(i / 2)) ? operand[8*(i%2) +: 8] :
                              old_word[8*i +: 8];
  end
endmodule

// File: rtl/subword_store_unit.sv
// subword_store_unit: narrows stores to byte/half via read-modify-write; full words write directly.
module subword_store_unit
  import cpu_types_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        done,
  output logic        misalign,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic [31:0] dmemload,
  input  logic        dhit
);
  sws_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, store_q, store_d, merged;
  mem_size_t   size_q, size_d, req_size;
  logic        misalign_q, misalign_d;

  assign req_size = mem_size_t'(size);

  subword_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_word(dmemload),
    .operand (wdata_q),
    .offset  (addr_q[1:0]),
    .size    (size_q),
    .merged  (merged)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    store_d    = store_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d     = addr;
        wdata_d    = wdata;
        size_d     = req_size;
        misalign_d = misaligned(req_size, addr[1:0]);
        store_d    = (req_size == WORD && !misalign_d) ? wdata : store_q;
        state_d    = misalign_d ? DONE : req_size == WORD ? WRITE : READ;
      end
      READ: if (dhit) begin
        store_d = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = dhit ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= BYTE;
      store_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      store_q    <= store_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmemREN   = state_q == READ;
  assign dmemWEN   = state_q == WRITE;
  assign done      = state_q == DONE;
  assign misalign  = misalign_q;
  assign dmemaddr  = {addr_q[31:2], 2'b00};
  assign dmemstore = store_q;
endmodule

// File: doc/subword_store_unit.md
Name: subword_store_unit

Overview:
- Narrowing counterpart to the immediate/load extenders: takes a 32-bit store operand plus an access size and writes only the selected byte or halfword to data memory.
- Sub-word stores run as a read-modify-write on the word-aligned location: read the word, merge the truncated operand into its lane, write the word back.
- Full-word stores issue a single write.
- Sits between the datapath's memory stage and the dmem request interface.

Parameters:
- BIG_ENDIAN, 1, lane order: 1 = byte offset 0 in bits [31:24]; 0 = byte offset 0 in bits [7:0].

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- req  input  1  store request; sampled only in IDLE
- addr  input  32  byte address of the store
- wdata  input  32  store operand; low 8/16/32 bits used per size
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- done  output  1  one-cycle pulse when the transaction ends
- misalign  output  1  valid with done; 1 = rejected, no memory access made
- dmemREN  output  1  memory read request
- dmemWEN  output  1  memory write request
- dmemaddr  output  32  word-aligned address {addr_q[31:2],2'b00}
- dmemstore  output  32  word to write
- dmemload  input  32  word returned by memory
- dhit  input  1  memory completion for the current REN/WEN

Behaviour:
- Reset: all outputs 0, state IDLE, latches cleared. Reset asserted mid-transaction takes effect immediately (async): REN/WEN drop in the same cycle, no done pulse, partial data discarded.
- States: IDLE, READ, WRITE, DONE. REN/WEN/done are Moore outputs of the state register.
- IDLE:
  - req=1 latches addr, wdata, size into addr_q, wdata_q, size_q.
  - Misaligned or reserved -> DONE with misalign=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=00. Reserved means size=11.
  - Word -> WRITE with dmemstore=wdata_q.
  - Byte/half -> READ.
- READ: dmemREN=1. On dhit, capture merged = merge(dmemload, wdata_q, addr_q[1:0], size_q) into dmemstore, then -> WRITE. Without dhit, stay; no timeout.
- WRITE: dmemWEN=1, dmemstore stable. On dhit -> DONE.
- DONE: done=1 for exactly one cycle, misalign held valid, then -> IDLE. misalign clears on the next acceptance.
- Merge with BIG_ENDIAN=1:
  - Byte offset k replaces bits [31-8k -: 8] with wdata_q[7:0].
  - Half offset 0 replaces [31:16] and half offset 2 replaces [15:0], each with wdata_q[15:0].
  - Mirrored when BIG_ENDIAN=0.
  - All other bits pass through from dmemload unchanged.
- req is not observed outside IDLE. Changes to addr/wdata/size mid-transaction have no effect.
- The requester must deassert req in the done cycle. If req is still high in IDLE the following cycle, a new transaction starts (back-to-back allowed).
- Minimum latency, dhit in the same cycle as the request:
  - word: 2 cycles accept-to-done
  - byte/half: 3 cycles accept-to-done
- dmemREN and dmemWEN are never asserted together.

Decomposition:
- cpu_types_pkg gains:
  - mem_size_t enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10, RSVD=2'b11.
  - sws_state_t enum: IDLE, READ, WRITE, DONE.
- One combinational sub-module, subword_merge (old word, operand, offset, size, BIG_ENDIAN -> merged word). It is reused later by the load-side lane extractor's tests.

Test Plan:
- Byte store: addr=0x104, wdata=0xAABBCCDD, size=BYTE, memory word 0x11223344, dhit immediate -> REN at 0x104, then WEN storing 0xDD223344, done after 3 cycles, misalign=0.
- Half store: addr=0x206, wdata=0x0000BEEF, size=HALF, memory 0xCAFEF00D -> dmemstore 0xCAFEBEEF. Repeat with BIG_ENDIAN=0 -> 0xBEEFF00D.
- Word store: addr=0x300, wdata=0x12345678, size=WORD -> no REN, WEN with 0x12345678, done after 2 cycles.
- Misaligned: half at addr=0x401 and word at addr=0x402, plus size=11 -> done with misalign=1, REN/WEN never asserted.
- Stall and reset: dhit withheld 5 cycles in READ -> REN held, no WEN. Then assert RST mid-WRITE -> WEN drops asynchronously, all outputs 0, no done pulse; after release, a new byte store completes normally.
- Back-to-back: req held high across done -> second transaction accepted in the IDLE cycle immediately after DONE, both merges correct.
